seq_mult_128: RTL and testbench
===============================

// Module: seq_mult_128
// PURPOSE
//  Unsigned 128x128 -> 256-bit sequential multiplier using radix-256 shift-and-add.
//  Captures operands once after reset release, then adds one 8-bit multiplier digit
//  per clock over 16 clocks. Holds the product with done=1 until the next reset.
//  Standalone arithmetic leaf; state and count are exported for debug and visibility.
// PARAMETERS
//  WIDTH  128  operand width; product is 2*WIDTH
//  DIGIT  8    multiplier bits consumed per CALC cycle; WIDTH/DIGIT = 16 digits
//  (count width = log2(WIDTH/DIGIT) = 4; ports below are sized for the defaults)
// PORTS
//  clk        in   1    rising-edge clock; the only clock
//  reset_n    in   1    synchronous, active-high reset (1 = reset)
//  a          in   128  multiplicand, unsigned
//  b          in   128  multiplier, unsigned
//  p          out  256  product a*b, registered; valid when done=1
//  done       out  1    high while p holds the final product
//  state_out  out  2    FSM state: 00 LOAD, 01 CALC, 10 DONE
//  count_out  out  4    index of the current multiplier digit
// BEHAVIOUR
//  - Reset (reset_n=1 at an edge):
//      state=LOAD, p=0, done=0, count=0, internal A/B/acc cleared.
//    Reset wins over all other activity, including mid-CALC; any partial result is discarded.
//  - LOAD (first edge with reset_n=0):
//      A<=a, B<=b, acc<=0, count<=0, ->CALC.
//    a and b are sampled only here; later input changes are ignored until the next reset.
//  - CALC, each edge:
//      acc <= acc + ((A*B[7:0]) << (8*count)); B <= B>>8.
//      If count==15: ->DONE, p<=next acc, done<=1, count holds 15.
//      Otherwise count<=count+1.
//  - DONE: p, done=1, state and count all hold until reset.
//  - Latency: done rises on the 17th rising edge after reset release (1 LOAD + 16 CALC).
//  - Arithmetic: acc is 256 bits. Each partial product is 136 bits, zero-extended.
//    The maximum product (2^128-1)^2 fits exactly; no overflow or wrap is possible.
//  - Illegal state 11: next edge goes to LOAD, done=0.
//  - Outputs are registered only; there are no combinational paths from inputs to outputs.
// CONFIGURATION
//  SEQMUL_EARLY_TERM_EN
//   Defined:
//    In CALC, when the shifted B (after this cycle's shift) equals 0, go to DONE
//    immediately and latch p. count holds its value at termination.
//    Latency is 1 + (number of nonzero-significant digits of b, minimum 1) edges.
//    Example: b=0 or b=1 -> done on the 2nd edge.
//   Undefined:
//    Always runs 16 CALC cycles; fixed 17-edge latency.
//   The product value is identical in both builds.
// TESTING
//  1. Reset, release, a=0, b=0 -> done=1 on edge 17, p=0, state_out=10, count_out=15.
//  2. a=3, b=5 -> p=15.
//     Check that state_out steps 00->01 (x16)->10 and count_out runs 0..15.
//  3. a=b=20'hFFFFF -> p=40'hFF_FFE0_0001.
//     Repeat the sweep a,b in {0,1,3,7,...,2^20-1}; every result must equal a*b.
//  4. a=b=128'hFFFF...FFFF -> p upper 128 bits = FF..FE, lower 128 bits = 00..01.
//  5. Assert reset_n=1 at count_out=7 -> next edge: p=0, done=0, state_out=00.
//     Release with new operands -> correct new product on edge 17.
//  6. Change a and b after the LOAD edge -> p still equals the product of the captured values.
//     With SEQMUL_EARLY_TERM_EN: b=0 -> done on edge 2; b=16'hFFFF -> done on edge 3.

Source files
------------

// File: rtl/seq_mult_128.sv
// -----------------------------------------------------------------------------
// seq_mult_128
//   Unsigned WIDTH x WIDTH -> 2*WIDTH sequential multiplier, radix-2^DIGIT
//   shift-and-add. Operands are captured once in LOAD after reset release,
//   one DIGIT-bit multiplier digit is accumulated per CALC clock, and the
//   final product is held in DONE until the next reset.
//
//   Optional feature macro: SEQMUL_EARLY_TERM_EN
//     defined   - leave CALC as soon as the remaining multiplier bits are zero
//     undefined - always run WIDTH/DIGIT CALC cycles (fixed latency)
//   The product value is the same in both builds.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset_n    in   1        synchronous reset, active HIGH (1 = reset)
//   a          in   WIDTH    multiplicand, unsigned (sampled in LOAD only)
//   b          in   WIDTH    multiplier, unsigned (sampled in LOAD only)
//   p          out  2*WIDTH  registered product, valid while done=1
//   done       out  1        high while p holds the final product
//   state_out  out  2        FSM state: 00 LOAD, 01 CALC, 10 DONE
//   count_out  out  CW       index of the current multiplier digit
// -----------------------------------------------------------------------------
module seq_mult_128 #(
  parameter  int WIDTH = 128,
  parameter  int DIGIT = 8,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p,
  output logic                 done,
  output logic [1:0]           state_out,
  output logic [CW-1:0]        count_out
);

  localparam int SHW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 done_q, done_d;

  // Datapath: one WIDTH x DIGIT partial product per cycle, placed at the
  // current digit position. The 2*WIDTH accumulator holds the full product,
  // so the sum can never overflow.
  logic [WIDTH+DIGIT-1:0] pp;
  logic [2*WIDTH-1:0]     pp_ext;
  logic [SHW-1:0]         shamt;
  logic [2*WIDTH-1:0]     acc_next;
  logic [WIDTH-1:0]       b_shift;
  logic                   last;

  assign pp       = {{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[DIGIT-1:0]};
  assign pp_ext   = {{(WIDTH-DIGIT){1'b0}}, pp};
  assign shamt    = SHW'(count_q) * SHW'(DIGIT);
  assign acc_next = acc_q + (pp_ext << shamt);
  assign b_shift  = b_q >> DIGIT;

`ifdef SEQMUL_EARLY_TERM_EN
  // Once the unconsumed multiplier bits are all zero, further digits add
  // nothing, so the product is already final.
  assign last = (b_shift == '0) || (count_q == LAST_DIGIT);
`else
  assign last = (count_q == LAST_DIGIT);
`endif

  // NOTE: every _d signal gets a hold default before the case statement, so
  // no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    count_d = count_q;
    done_d  = done_q;

    case (state_q)
      ST_LOAD: begin
        a_d     = a;
        b_d     = b;
        acc_d   = '0;
        count_d = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        acc_d = acc_next;
        b_d   = b_shift;
        if (last) begin
          state_d = ST_DONE;
          p_d     = acc_next;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      ST_DONE: ;
      default: begin
        // Unreachable encoding 2'b11: recover through LOAD.
        state_d = ST_LOAD;
        done_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= ST_LOAD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign p         = p_q;
  assign done      = done_q;
  assign state_out = state_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_seq_mult_128.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_128
//   Scoreboard bench for seq_mult_128. The stimulus process issues one
//   multiplication per reset/release cycle and pushes the expected product
//   and latency into a queue; a monitor pops and compares whenever done
//   rises. A second monitor checks the visible state/count/done/p trace
//   every cycle against the edge count since reset release.
// -----------------------------------------------------------------------------
module tb_seq_mult_128;

  typedef struct {
    logic [255:0] prod;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [127:0] a = '0;
  logic [127:0] b = '0;
  logic [255:0] p;
  logic         done;
  logic [1:0]   state_out;
  logic [3:0]   count_out;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  int cur_lat = 17;   // written by stimulus while reset is asserted
  int mon_lat = 17;   // captured by the monitor at each reset edge
  int edges   = 0;    // rising edges since the last reset edge
  bit trace_ok = 1'b0;
  bit done_seen = 1'b0;

  seq_mult_128 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .p         (p),
    .done      (done),
    .state_out (state_out),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: product by plain 256-bit arithmetic, latency from the digit
  // count of the multiplier.
  function automatic logic [255:0] ref_prod(input logic [127:0] av,
                                            input logic [127:0] bv);
    logic [255:0] x, y;
    x = {128'b0, av};
    y = {128'b0, bv};
    return x * y;
  endfunction

  function automatic int ref_lat(input logic [127:0] bv);
`ifdef SEQMUL_EARLY_TERM_EN
    int d = 1;
    for (int i = 0; i < 16; i++)
      if (bv[8*i +: 8] != 8'd0) d = i + 1;
    return 1 + d;
`else
    return 17;
`endif
  endfunction

  // Edge counter: reset_n only changes on falling edges, so it is stable here.
  always @(posedge clk) begin
    if (reset_n) begin
      edges    = 0;
      mon_lat  = cur_lat;
      trace_ok = 1'b1;
    end else begin
      edges++;
    end
  end

  // Trace monitor: after e edges from release the block is in LOAD (e=0),
  // CALC on digit e-1 (1 <= e < lat) or DONE holding digit lat-2 (e >= lat).
  always @(negedge clk) begin
    if (trace_ok) begin
      if (edges == 0) begin
        check("st_load", {254'b0, state_out}, 256'd0);
        check("cnt_load", {252'b0, count_out}, 256'd0);
        check("done_load", {255'b0, done}, 256'd0);
        check("p_load", p, 256'd0);
      end else if (edges < mon_lat) begin
        check("st_calc", {254'b0, state_out}, 256'd1);
        check("cnt_calc", {252'b0, count_out}, 256'(edges - 1));
        check("done_calc", {255'b0, done}, 256'd0);
        check("p_calc", p, 256'd0);
      end else begin
        check("st_done", {254'b0, state_out}, 256'd2);
        check("cnt_done", {252'b0, count_out}, 256'(mon_lat - 2));
        check("done_done", {255'b0, done}, 256'd1);
      end
    end
  end

  // Scoreboard monitor: compare on each rising of done.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 256'd1, 256'd0);
      end else begin
        e = sb_q.pop_front();
        check("product", p, e.prod);
        check("latency", 256'(edges), 256'(e.lat));
      end
    end else if (done !== 1'b1) begin
      done_seen = 1'b0;
    end
  end

  // One operation: reset for one edge, release with operands. abort_at >= 0
  // stops waiting once CALC reaches that digit (the next op's reset aborts it).
  task automatic run_op(input logic [127:0] av, input logic [127:0] bv,
                        input int abort_at, input bit perturb);
    exp_t e;
    @(negedge clk);
    reset_n = 1'b1;
    a       = av;
    b       = bv;
    cur_lat = ref_lat(bv);
    @(negedge clk);
    if (abort_at < 0) begin
      e.prod = ref_prod(av, bv);
      e.lat  = cur_lat;
      sb_q.push_back(e);
    end
    reset_n = 1'b0;
    @(negedge clk);               // LOAD edge has captured a and b
    if (perturb) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
    end
    if (abort_at >= 0) begin
      for (int i = 0; i < 40 && !(state_out == 2'b01 && count_out == 4'(abort_at)); i++)
        @(negedge clk);
      check("abort_reach", {252'b0, count_out}, 256'(abort_at));
    end else begin
      for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
      check("done_timeout", {255'b0, done}, 256'd1);
      repeat (2) @(negedge clk);  // DONE must hold
    end
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] ra, rb;
    ones = '1;

    // Zero operands, then a small product with a full trace.
    run_op(128'd0, 128'd0, -1, 1'b0);
    run_op(128'd3, 128'd5, -1, 1'b0);
    check("p_3x5", p, 256'd15);

    run_op(128'hFFFFF, 128'hFFFFF, -1, 1'b0);
    check("p_fffff_sq", p, 256'hFF_FFE0_0001);

    // Maximum operands: upper half 2^128-2, lower half 1.
    run_op(ones, ones, -1, 1'b0);
    check("p_max_hi", {128'b0, p[255:128]}, {128'b0, ones - 128'd1});
    check("p_max_lo", {128'b0, p[127:0]}, 256'd1);

    // Abort mid-CALC at digit 7, then a fresh operation.
    run_op(ones, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 7, 1'b0);
    run_op(128'hDEAD_BEEF, 128'hCAFE_F00D, -1, 1'b0);

    // Inputs change after LOAD; the captured operands must be used.
    run_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hFFFF, -1, 1'b1);
    run_op(128'h77, 128'd0, -1, 1'b1);
    run_op(128'd1, 128'd1, -1, 1'b1);

    // Sweep a, b over 2^k-1 for k = 0..20.
    for (int i = 0; i <= 20; i++)
      for (int j = 0; j <= 20; j++)
        run_op(128'((64'd1 << i) - 64'd1), 128'((64'd1 << j) - 64'd1), -1, 1'b0);

    // Random full-width operands, some with short multipliers.
    for (int k = 0; k < 30; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (k % 3 == 1) rb = rb >> ($urandom_range(127, 1));
      run_op(ra, rb, -1, k[0]);
    end

    @(negedge clk);
    check("sb_empty", 256'(sb_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
